// File: rtl/icache_responder.sv
// Purpose : read-only direct-mapped instruction cache; wishbone slave to fetch, wishbone master to memory.
// Latency : hit acks in the request cycle; a miss acks one cycle after the memory ACK that fills the line.
// Backpressure: the CPU is held (ACK low) during fills; CPU writes get RTY; memory RTY triggers a one-cycle gap and a retry.
//
// Ports:
//   i_clk, i_reset (sync, active-high), i_invalidate (one-cycle pulse, clears every valid bit)
//   i_cpu_* / o_cpu_* : fetch-side wishbone slave (ADR[11:0] line address, 128-bit data, ACK/RTY)
//   o_mem_* / i_mem_* : memory-side wishbone master, same signal set and widths
//   o_hit_count, o_miss_count : saturating performance counters, present only when ICACHE_PERF_EN is defined
module icache_responder #(
  parameter int NUM_SETS = 8
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_invalidate,
  // fetch-side slave
  input  logic         i_cpu_cyc,
  input  logic         i_cpu_stb,
  input  logic         i_cpu_we,
  input  logic [11:0]  i_cpu_adr,
  input  logic [15:0]  i_cpu_sel,
  input  logic [127:0] i_cpu_dat_m,
  output logic [127:0] o_cpu_dat_s,
  output logic         o_cpu_ack,
  output logic         o_cpu_rty,
  // memory-side master
  output logic         o_mem_cyc,
  output logic         o_mem_stb,
  output logic         o_mem_we,
  output logic [11:0]  o_mem_adr,
  output logic [15:0]  o_mem_sel,
  output logic [127:0] o_mem_dat_m,
  input  logic [127:0] i_mem_dat_s,
  input  logic         i_mem_ack,
  input  logic         i_mem_rty
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]  o_hit_count,
  output logic [31:0]  o_miss_count
`endif
);

  localparam int INDEX_W = $clog2(NUM_SETS);
  localparam int TAG_W   = 12 - INDEX_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_RETRY = 2'd2
  } state_t;

  // Line storage. Only the valid bits need a reset; tag/data are qualified by them.
  logic [NUM_SETS-1:0] r_valid;
  logic [TAG_W-1:0]    r_tag  [NUM_SETS];
  logic [127:0]        r_data [NUM_SETS];

  state_t      r_state;
  state_t      w_state_nxt;
  logic [11:0] r_fill_adr;
  logic [11:0] w_fill_adr_nxt;
  logic        r_kill;
  logic        w_kill_nxt;

  logic               w_req;
  logic               w_rd_req;
  logic               w_hit;
  logic [INDEX_W-1:0] w_index;
  logic [TAG_W-1:0]   w_tag;
  logic [INDEX_W-1:0] w_fill_index;
  logic [TAG_W-1:0]   w_fill_tag;
  logic               w_fill_we;

  // The whole line is always returned and the array is read-only from the CPU side,
  // so byte selects and write data are never consumed.
  logic w_unused;
  assign w_unused = ^{i_cpu_sel, i_cpu_dat_m};

  assign w_req    = i_cpu_cyc & i_cpu_stb;
  assign w_rd_req = w_req & ~i_cpu_we;
  assign w_index  = i_cpu_adr[INDEX_W-1:0];
  assign w_tag    = i_cpu_adr[11:INDEX_W];
  assign w_hit    = w_rd_req & r_valid[w_index] & (r_tag[w_index] == w_tag);

  assign w_fill_index = r_fill_adr[INDEX_W-1:0];
  assign w_fill_tag   = r_fill_adr[11:INDEX_W];
  // RTY wins over a simultaneous ACK, so such a beat never writes the array.
  assign w_fill_we    = (r_state == S_FETCH) & i_mem_ack & ~i_mem_rty;

  // Writes are refused in every state, independent of the FSM.
  assign o_cpu_rty = w_req & i_cpu_we;

  // ---------------------------------------------------------------------------
  // FSM next-state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_fill_adr_nxt = r_fill_adr;
    w_kill_nxt     = r_kill;
    o_cpu_ack      = 1'b0;
    o_mem_cyc      = 1'b0;
    o_mem_stb      = 1'b0;
    o_mem_we       = 1'b0;
    o_mem_adr      = 12'h000;
    o_mem_sel      = 16'h0000;
    o_mem_dat_m    = '0;

    case (r_state)
      S_IDLE: begin
        o_cpu_ack = w_hit;
        // A miss that collides with invalidate is simply re-evaluated next cycle.
        if (w_rd_req && !w_hit && !i_invalidate) begin
          w_state_nxt    = S_FETCH;
          w_fill_adr_nxt = i_cpu_adr;
          w_kill_nxt     = 1'b0;
        end
      end

      S_FETCH: begin
        o_mem_cyc = 1'b1;
        o_mem_stb = 1'b1;
        o_mem_adr = r_fill_adr;
        o_mem_sel = 16'hFFFF;
        if (i_invalidate) begin
          w_kill_nxt = 1'b1;
        end
        if (i_mem_rty) begin
          w_state_nxt = S_RETRY;
        end else if (i_mem_ack) begin
          w_state_nxt = S_IDLE;
        end
      end

      S_RETRY: begin
        // Bus released for exactly this cycle, then the same fill is reissued.
        if (i_invalidate) begin
          w_kill_nxt = 1'b1;
        end
        w_state_nxt = S_FETCH;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign o_cpu_dat_s = o_cpu_ack ? r_data[w_index] : '0;

  // ---------------------------------------------------------------------------
  // State, fill address, kill flag and valid bits
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_fill_adr <= 12'h000;
      r_kill     <= 1'b0;
      r_valid    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fill_adr <= w_fill_adr_nxt;
      r_kill     <= w_kill_nxt;
      if (i_invalidate) begin
        r_valid <= '0;
      end
      // A fill that was overtaken by an invalidate (earlier or in this very
      // cycle) still lands its data but leaves the line invalid.
      if (w_fill_we) begin
        r_valid[w_fill_index] <= ~(r_kill | i_invalidate);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_fill_we) begin
      r_tag[w_fill_index]  <= w_fill_tag;
      r_data[w_fill_index] <= i_mem_dat_s;
    end
  end

`ifdef ICACHE_PERF_EN
  // ---------------------------------------------------------------------------
  // Saturating hit/miss counters; only reset clears them.
  // ---------------------------------------------------------------------------
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_hit_count  <= 32'h0;
      r_miss_count <= 32'h0;
    end else begin
      if (o_cpu_ack && (r_hit_count != 32'hFFFF_FFFF)) begin
        r_hit_count <= r_hit_count + 32'h1;
      end
      if ((r_state == S_IDLE) && (w_state_nxt == S_FETCH) &&
          (r_miss_count != 32'hFFFF_FFFF)) begin
        r_miss_count <= r_miss_count + 32'h1;
      end
    end
  end

  assign o_hit_count  = r_hit_count;
  assign o_miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_icache_responder.sv
// Purpose : self-checking bench for icache_responder (vector table, corner sequences, random traffic vs. a line-level model).
// Latency : inputs driven 1ns after the rising edge, outputs sampled on the falling edge.
// Backpressure: an in-bench memory responder answers fills after a programmable latency, optionally with RTY first.
module tb_icache_responder;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         invalidate = 1'b0;
  logic         cpu_cyc = 1'b0;
  logic         cpu_stb = 1'b0;
  logic         cpu_we = 1'b0;
  logic [11:0]  cpu_adr = 12'h000;
  logic [15:0]  cpu_sel = 16'hFFFF;
  logic [127:0] cpu_dat_m = '0;
  logic [127:0] cpu_dat_s;
  logic         cpu_ack;
  logic         cpu_rty;
  logic         mem_cyc;
  logic         mem_stb;
  logic         mem_we;
  logic [11:0]  mem_adr;
  logic [15:0]  mem_sel;
  logic [127:0] mem_dat_m;
  logic [127:0] mem_dat_s = '0;
  logic         mem_ack = 1'b0;
  logic         mem_rty = 1'b0;
`ifdef ICACHE_PERF_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  icache_responder #(.NUM_SETS(8)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_invalidate (invalidate),
    .i_cpu_cyc    (cpu_cyc),
    .i_cpu_stb    (cpu_stb),
    .i_cpu_we     (cpu_we),
    .i_cpu_adr    (cpu_adr),
    .i_cpu_sel    (cpu_sel),
    .i_cpu_dat_m  (cpu_dat_m),
    .o_cpu_dat_s  (cpu_dat_s),
    .o_cpu_ack    (cpu_ack),
    .o_cpu_rty    (cpu_rty),
    .o_mem_cyc    (mem_cyc),
    .o_mem_stb    (mem_stb),
    .o_mem_we     (mem_we),
    .o_mem_adr    (mem_adr),
    .o_mem_sel    (mem_sel),
    .o_mem_dat_m  (mem_dat_m),
    .i_mem_dat_s  (mem_dat_s),
    .i_mem_ack    (mem_ack),
    .i_mem_rty    (mem_rty)
`ifdef ICACHE_PERF_EN
    ,
    .o_hit_count  (hit_count),
    .o_miss_count (miss_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // memory responder state and per-transaction observations
  int          mem_lat = 1;
  int          mem_rty_left = 0;
  int          mem_cnt = 0;
  int          obs_cyc = 0;
  int          obs_fills = 0;
  int          obs_bad_bus = 0;
  logic [11:0] exp_mem_adr = 12'h000;

  // line-level reference model: which address each set holds
  bit          ref_vld [8];
  logic [11:0] ref_adr [8];

  typedef struct {
    logic [11:0] adr;
    bit          we;
    int          lat;
    int          rty;
    int          exp_lat;
    int          exp_cyc;
    int          exp_fills;
  } vec_t;

  function automatic logic [127:0] memdata(input logic [11:0] a);
    logic [127:0] d;
    d = {16{a[7:0] ^ 8'hA0}};
    d[127:124] = d[127:124] ^ a[11:8];
    return d;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Memory side: answers the mem_lat-th STB cycle of each attempt.
  task automatic mem_respond();
    mem_ack   = 1'b0;
    mem_rty   = 1'b0;
    mem_dat_s = '0;
    if (mem_cyc && mem_stb) begin
      mem_cnt++;
      if (mem_cnt >= mem_lat) begin
        mem_cnt = 0;
        if (mem_rty_left > 0) begin
          mem_rty = 1'b1;
          mem_rty_left--;
        end else begin
          mem_ack   = 1'b1;
          mem_dat_s = memdata(mem_adr);
        end
      end
    end else begin
      mem_cnt = 0;
    end
  endtask

  task automatic cyc_begin();
    @(posedge clk);
    #1;
    mem_respond();
  endtask

  task automatic cyc_end();
    @(negedge clk);
    if (mem_cyc) begin
      obs_cyc++;
      if (mem_adr != exp_mem_adr || mem_we || mem_sel != 16'hFFFF || !mem_stb) obs_bad_bus++;
      if (mem_ack && !mem_rty) obs_fills++;
    end
  endtask

  task automatic clear_obs(input logic [11:0] adr);
    exp_mem_adr = adr;
    obs_cyc     = 0;
    obs_fills   = 0;
    obs_bad_bus = 0;
  endtask

  // Holds a read until ACK (bounded); lat = cycles after the first request cycle.
  task automatic cpu_read(input logic [11:0] adr, output int lat, output logic [127:0] dat);
    clear_obs(adr);
    lat = 0;
    cyc_begin();
    cpu_cyc = 1'b1; cpu_stb = 1'b1; cpu_we = 1'b0; cpu_adr = adr;
    cyc_end();
    while (!cpu_ack && lat < 200) begin
      cyc_begin();
      cyc_end();
      lat++;
    end
    dat = cpu_dat_s;
  endtask

  task automatic cpu_write(input logic [11:0] adr);
    clear_obs(adr);
    cyc_begin();
    cpu_cyc = 1'b1; cpu_stb = 1'b1; cpu_we = 1'b1; cpu_adr = adr;
    cyc_end();
    check("wr_rty", 128'(cpu_rty), 128'(1));
    check("wr_ack", 128'(cpu_ack), 128'(0));
    check("wr_mem_cyc", 128'(mem_cyc), 128'(0));
    cyc_begin();
    cpu_cyc = 1'b0; cpu_stb = 1'b0; cpu_we = 1'b0;
    cyc_end();
    check("wr_rty_clear", 128'(cpu_rty), 128'(0));
  endtask

  task automatic do_reset();
    cyc_begin();
    reset = 1'b1; cpu_cyc = 1'b0; cpu_stb = 1'b0; cpu_we = 1'b0; invalidate = 1'b0;
    cyc_end();
    cyc_begin();
    cyc_end();
    cyc_begin();
    reset = 1'b0;
    cyc_end();
  endtask

  initial begin
    vec_t         tbl [10];
    int           lat;
    logic [127:0] dat;

    // cold miss, hits, conflict eviction, memory RTY, write refusal, second set
    tbl[0] = '{12'h005, 1'b0, 3, 0, 4, 3, 1};
    tbl[1] = '{12'h005, 1'b0, 1, 0, 0, 0, 0};
    tbl[2] = '{12'h005, 1'b0, 1, 0, 0, 0, 0};
    tbl[3] = '{12'h00D, 1'b0, 2, 0, 3, 2, 1};
    tbl[4] = '{12'h005, 1'b0, 1, 1, 4, 2, 1};
    tbl[5] = '{12'h00D, 1'b0, 2, 1, 6, 4, 1};
    tbl[6] = '{12'h123, 1'b1, 1, 0, 0, 0, 0};
    tbl[7] = '{12'h003, 1'b0, 1, 0, 2, 1, 1};
    tbl[8] = '{12'h003, 1'b0, 1, 0, 0, 0, 0};
    tbl[9] = '{12'h00D, 1'b0, 1, 0, 0, 0, 0};

    // ---- reset state ----
    cyc_begin();
    reset = 1'b1;
    cyc_end();
    cyc_begin();
    cyc_end();
    check("rst_cpu_ack", 128'(cpu_ack), 128'(0));
    check("rst_cpu_rty", 128'(cpu_rty), 128'(0));
    check("rst_cpu_dat", cpu_dat_s, 128'(0));
    check("rst_mem_cyc_stb_we", 128'({mem_cyc, mem_stb, mem_we}), 128'(0));
    check("rst_mem_adr", 128'(mem_adr), 128'(0));
`ifdef ICACHE_PERF_EN
    check("rst_counters", 128'({hit_count, miss_count}), 128'(0));
`endif
    cyc_begin();
    reset = 1'b0;
    cyc_end();

    // ---- vector table ----
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].we) begin
        cpu_write(tbl[i].adr);
      end else begin
        mem_lat      = tbl[i].lat;
        mem_rty_left = tbl[i].rty;
        cpu_read(tbl[i].adr, lat, dat);
        check($sformatf("tbl%0d_lat", i), 128'(lat), 128'(tbl[i].exp_lat));
        check($sformatf("tbl%0d_dat", i), dat, memdata(tbl[i].adr));
        check($sformatf("tbl%0d_mem_cycles", i), 128'(obs_cyc), 128'(tbl[i].exp_cyc));
        check($sformatf("tbl%0d_fills", i), 128'(obs_fills), 128'(tbl[i].exp_fills));
        check($sformatf("tbl%0d_mem_bus", i), 128'(obs_bad_bus), 128'(0));
      end
`ifdef ICACHE_PERF_EN
      if (i == 2) begin
        cyc_begin();
        cpu_cyc = 1'b0; cpu_stb = 1'b0;
        cyc_end();
        check("perf_miss_count", 128'(miss_count), 128'(1));
        check("perf_hit_count", 128'(hit_count), 128'(3));
      end
`endif
    end

    // ---- invalidate in IDLE: same-cycle hit still acks, line gone afterwards ----
    cyc_begin();
    cpu_cyc = 1'b1; cpu_stb = 1'b1; cpu_we = 1'b0; cpu_adr = 12'h003; invalidate = 1'b1;
    cyc_end();
    check("inv_idle_ack", 128'(cpu_ack), 128'(1));
    check("inv_idle_dat", cpu_dat_s, memdata(12'h003));
    cyc_begin();
    invalidate = 1'b0; cpu_cyc = 1'b0; cpu_stb = 1'b0;
    cyc_end();
    mem_lat = 1; mem_rty_left = 0;
    cpu_read(12'h003, lat, dat);
    check("inv_idle_reread_lat", 128'(lat), 128'(2));

    // ---- invalidate mid-fill: first fill is discarded, a second fill follows ----
    mem_lat = 4; mem_rty_left = 0;
    clear_obs(12'h020);
    lat = 0;
    cyc_begin();
    cpu_cyc = 1'b1; cpu_stb = 1'b1; cpu_we = 1'b0; cpu_adr = 12'h020;
    cyc_end();
    while (!cpu_ack && lat < 200) begin
      cyc_begin();
      invalidate = (lat == 1);
      cyc_end();
      lat++;
    end
    invalidate = 1'b0;
    check("inv_fill_fills", 128'(obs_fills), 128'(2));
    check("inv_fill_lat", 128'(lat), 128'(10));
    check("inv_fill_dat", cpu_dat_s, memdata(12'h020));
    check("inv_fill_mem_bus", 128'(obs_bad_bus), 128'(0));
    cpu_read(12'h020, lat, dat);
    check("inv_fill_rehit_lat", 128'(lat), 128'(0));

    // ---- reset in FETCH, then a stray memory ACK in IDLE ----
    mem_lat = 10; mem_rty_left = 0;
    clear_obs(12'h045);
    cyc_begin();
    cpu_cyc = 1'b1; cpu_stb = 1'b1; cpu_we = 1'b0; cpu_adr = 12'h045;
    cyc_end();
    cyc_begin();
    cyc_end();
    check("rstfill_fetching", 128'({mem_cyc, mem_adr}), 128'({1'b1, 12'h045}));
    cyc_begin();
    reset = 1'b1;
    cyc_end();
    cyc_begin();
    reset = 1'b0; cpu_cyc = 1'b0; cpu_stb = 1'b0;
    mem_ack = 1'b1; mem_dat_s = '1;
    cyc_end();
    check("rstfill_cyc_drop", 128'({mem_cyc, mem_stb}), 128'(0));
    cyc_begin();
    cyc_end();
    check("rstfill_late_ack_ignored", 128'({mem_cyc, cpu_ack}), 128'(0));
    mem_lat = 1;
    cpu_read(12'h020, lat, dat);
    check("rstfill_miss_020", 128'(lat), 128'(2));
    check("rstfill_dat_020", dat, memdata(12'h020));
    cpu_read(12'h00D, lat, dat);
    check("rstfill_miss_00D", 128'(lat), 128'(2));

    // ---- randomized traffic against the line-level model ----
    do_reset();
    for (int s = 0; s < 8; s++) begin
      ref_vld[s] = 1'b0;
      ref_adr[s] = 12'h000;
    end
    for (int n = 0; n < 200; n++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if (op == 0) begin
        cpu_write(12'($urandom_range(0, 4095)));
      end else if (op == 1) begin
        cyc_begin();
        cpu_cyc = 1'b0; cpu_stb = 1'b0; invalidate = 1'b1;
        cyc_end();
        cyc_begin();
        invalidate = 1'b0;
        cyc_end();
        for (int s = 0; s < 8; s++) ref_vld[s] = 1'b0;
      end else begin
        int          set_i;
        int          exp_lat;
        logic [11:0] a;
        set_i        = int'($urandom_range(0, 7));
        a            = 12'(int'($urandom_range(0, 2)) * 8 + set_i);
        mem_lat      = int'($urandom_range(1, 4));
        mem_rty_left = int'($urandom_range(0, 1));
        if (ref_vld[set_i] && ref_adr[set_i] == a)
          exp_lat = 0;
        else
          exp_lat = (mem_rty_left + 1) * mem_lat + mem_rty_left + 1;
        cpu_read(a, lat, dat);
        check($sformatf("rnd%0d_lat_%0h", n, a), 128'(lat), 128'(exp_lat));
        check($sformatf("rnd%0d_dat_%0h", n, a), dat, memdata(a));
        ref_vld[set_i] = 1'b1;
        ref_adr[set_i] = a;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
